fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the team's async FIFO among NUM_REQ requesters.
- Arbitration happens in the write-clock domain.
- Grants a burst of up to BURST_LEN words to one requester, then re-arbitrates.
- Applies FIFO full backpressure to the owner through a valid/ready handshake, and tags each write with the owner index.

Parameters:
- WIDTH, 4, data word width (matches FIFO WIDTH).
- NUM_REQ, 2, number of requesters, 2..4.
- BURST_LEN, 4, maximum words per grant, 1..15.

Ports:
- clk  in  1  write-domain clock.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester word valid.
- req_data  in  NUM_REQ*WIDTH  packed data; requester i occupies bits [i*WIDTH +: WIDTH].
- req_ready  out  NUM_REQ  per-requester accept.
- fifo_full  in  1  FIFO full flag, already synchronous to clk.
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_wdata  out  WIDTH  FIFO write data.
- fifo_wtag  out  clog2(NUM_REQ)  owner index of the current write.
- grant_owner  out  clog2(NUM_REQ)  current or last owner.
- busy  out  1  high while in BURST.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, burst_cnt=0, last_owner=NUM_REQ-1.
  - All outputs 0, including req_ready, fifo_wr_en, fifo_wdata, fifo_wtag and grant_owner.
- State machine has two states: IDLE and BURST.
- IDLE:
  - req_ready=0 and fifo_wr_en=0.
  - If any req_valid is high, pick the first valid index searching from last_owner+1 with wrap (round-robin).
  - Register that index as owner, set burst_cnt=0 and go to BURST on the next edge. Arbitration costs one cycle.
- BURST:
  - req_ready[owner] = !fifo_full; every other req_ready is 0.
  - fifo_wr_en = req_valid[owner] & !fifo_full. This is combinational, zero latency.
  - fifo_wdata = req_data slice of the owner; fifo_wtag = owner.
  - Each accepted word increments burst_cnt.
  - Go to IDLE on the next edge when either:
    - the accepted word brings burst_cnt to BURST_LEN, or
    - req_valid[owner]=0 (early release).
  - On that transition, last_owner takes the value of owner.
- fifo_full in BURST: the owner holds its grant and stalls. There are no writes while full, burst_cnt does not advance, and there is no timeout.
- Words are never dropped or duplicated. A write occurs only when the valid&ready handshake completes.
- Simultaneous requests are resolved strictly by round-robin. A requester that just finished a burst has lowest priority in the next arbitration.
- Wrap: round-robin search modulo NUM_REQ. burst_cnt width is clog2(BURST_LEN+1).
- Reset mid-burst: everything returns immediately to reset values. The partial burst is abandoned; already-written words remain in the FIFO.
- grant_owner is held stable in IDLE.
- busy = (state==BURST).

Optional Feature:
- Macro: FIFO_WR_ARB_STATS_EN.
- When defined:
  - Adds output stall_cycles (16 bit, saturating): counts BURST cycles with req_valid[owner]=1 and fifo_full=1.
  - Adds output grant_count (NUM_REQ*8 bit, per-requester wrapping counters): each counter increments on IDLE->BURST for that owner.
  - Both outputs clear on rst.
- When undefined: neither port nor counter exists. Core behaviour is identical either way.

Decomposition:
- Package fifo_arb_pkg holds:
  - state enum {IDLE, BURST};
  - localparam function for owner-index width;
  - default WIDTH/BURST_LEN constants shared with the FIFO top.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req vector, last index.
  - Outputs: grant index, any_valid.

Test Plan:
- NUM_REQ=2, BURST_LEN=4. Requester 0 holds valid with data 1,2,3,4,5 and requester 1 is idle.
  - 1 arbitration cycle, then writes 1,2,3,4 on consecutive cycles with tag 0.
  - IDLE for 1 cycle, then regrant to 0, which writes 5.
- Both requesters valid continuously, r0 data 0xA, r1 data 0x5.
  - Write sequence: 4×0xA tag0, then 4×0x5 tag1, then 4×0xA, alternating.
  - One bubble cycle between bursts.
- fifo_full asserted for 3 cycles mid-burst after 2 words.
  - fifo_wr_en=0 and req_ready[owner]=0 for those 3 cycles.
  - Remaining 2 words written after full deasserts; total burst is exactly 4.
- Owner drops valid after 1 word.
  - Return to IDLE next edge and grant the other pending requester.
  - fifo_wtag changes accordingly.
- rst pulse of 1 cycle mid-burst.
  - All outputs 0 asynchronously and busy=0.
  - After release, the first grant goes to requester 0 (last_owner reset to 1).
- Stats: define FIFO_WR_ARB_STATS_EN and rerun the full-stall scenario. Expect stall_cycles=3 and grant_count[0]=1.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and constants for the FIFO write-port arbiter and the FIFO top.
package fifo_arb_pkg;

    localparam int unsigned DEF_WIDTH     = 4;
    localparam int unsigned DEF_NUM_REQ   = 2;
    localparam int unsigned DEF_BURST_LEN = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Owner-index width; never below 1 so single-bit selects stay legal.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO-side bundle of the write arbiter; slave = arbiter, master = environment.
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned NUM_REQ = DEF_NUM_REQ
);
    localparam int unsigned IW = idx_w(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     fifo_full;
    logic                     fifo_wr_en;
    logic [WIDTH-1:0]         fifo_wdata;
    logic [IW-1:0]            fifo_wtag;
    logic [IW-1:0]            grant_owner;
    logic                     busy;

    modport master (
        output req_valid, req_data, fifo_full,
        input  req_ready, fifo_wr_en, fifo_wdata, fifo_wtag, grant_owner, busy
    );

    modport slave (
        input  req_valid, req_data, fifo_full,
        output req_ready, fifo_wr_en, fifo_wdata, fifo_wtag, grant_owner, busy
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after i_last, with wrap.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    localparam int unsigned IW     = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IW-1:0]      i_last,
    output logic [IW-1:0]      o_grant,
    output logic               o_any_valid
);

    int unsigned w_dist;
    int unsigned w_best;

    // Distance 0 is i_last+1; i_last itself is farthest, so it has lowest priority.
    always_comb begin
        o_grant     = '0;
        o_any_valid = 1'b0;
        w_dist      = 0;
        w_best      = NUM_REQ;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            w_dist = (j + NUM_REQ - 1 - int'(i_last)) % NUM_REQ;
            if (i_req[j] && (w_dist < w_best)) begin
                w_best      = w_dist;
                o_grant     = IW'(j);
                o_any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for the async FIFO write port.
// Optional statistics outputs enabled by defining FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
    parameter int unsigned BURST_LEN = DEF_BURST_LEN
) (
    input  logic                 clk,
    input  logic                 rst,
    fifo_wr_arbiter_if.slave     bus
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [15:0]          stall_cycles,
    output logic [NUM_REQ*8-1:0] grant_count
`endif
);

    localparam int unsigned IW = idx_w(NUM_REQ);
    localparam int unsigned CW = $clog2(BURST_LEN + 1);

    arb_state_t    r_state;
    logic [IW-1:0] r_owner;
    logic [IW-1:0] r_last;
    logic [CW-1:0] r_cnt;

    logic [IW-1:0]    w_pick;
    logic             w_any;
    logic             w_busy;
    logic             w_own_valid;
    logic [WIDTH-1:0] w_own_data;
    logic             w_accept;

`ifdef FIFO_WR_ARB_STATS_EN
    logic [15:0]          r_stall_cycles;
    logic [NUM_REQ*8-1:0] r_grant_count;

    assign stall_cycles = r_stall_cycles;
    assign grant_count  = r_grant_count;
`endif

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .i_req       (bus.req_valid),
        .i_last      (r_last),
        .o_grant     (w_pick),
        .o_any_valid (w_any)
    );

    always_comb begin
        w_own_valid = 1'b0;
        w_own_data  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (IW'(i) == r_owner) begin
                w_own_valid = bus.req_valid[i];
                w_own_data  = bus.req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_busy   = (r_state == BURST);
    assign w_accept = w_busy & w_own_valid & ~bus.fifo_full;

    // Data/tag gated by state so the async reset clears them immediately.
    assign bus.busy        = w_busy;
    assign bus.fifo_wr_en  = w_accept;
    assign bus.fifo_wdata  = w_busy ? w_own_data : '0;
    assign bus.fifo_wtag   = w_busy ? r_owner : '0;
    assign bus.grant_owner = r_owner;

    always_comb begin
        bus.req_ready = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            bus.req_ready[i] = w_busy && (IW'(i) == r_owner) && !bus.fifo_full;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_last  <= IW'(NUM_REQ - 1);
            r_cnt   <= '0;
`ifdef FIFO_WR_ARB_STATS_EN
            r_stall_cycles <= '0;
            r_grant_count  <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_owner <= w_pick;
                        r_cnt   <= '0;
                        r_state <= BURST;
`ifdef FIFO_WR_ARB_STATS_EN
                        for (int unsigned i = 0; i < NUM_REQ; i++) begin
                            if (IW'(i) == w_pick) begin
                                r_grant_count[i*8 +: 8] <= r_grant_count[i*8 +: 8] + 8'd1;
                            end
                        end
`endif
                    end
                end
                BURST: begin
                    if (!w_own_valid) begin
                        r_state <= IDLE;
                        r_last  <= r_owner;
                    end else if (w_accept) begin
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == CW'(BURST_LEN - 1)) begin
                            r_state <= IDLE;
                            r_last  <= r_owner;
                        end
                    end else begin
`ifdef FIFO_WR_ARB_STATS_EN
                        if (r_stall_cycles != '1) begin
                            r_stall_cycles <= r_stall_cycles + 16'd1;
                        end
`endif
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter; stats checks compiled when FIFO_WR_ARB_STATS_EN is defined.
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    localparam int unsigned W  = 4;
    localparam int unsigned N  = 2;
    localparam int unsigned BL = 4;

    typedef struct packed {
        logic [W-1:0] d;
        logic         t;
    } wr_t;

    logic clk = 1'b0;
    logic rst;

    fifo_wr_arbiter_if #(.WIDTH(W), .NUM_REQ(N)) bus ();

`ifdef FIFO_WR_ARB_STATS_EN
    logic [15:0]    stall_cycles;
    logic [N*8-1:0] grant_count;
`endif

    fifo_wr_arbiter #(.WIDTH(W), .NUM_REQ(N), .BURST_LEN(BL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
`ifdef FIFO_WR_ARB_STATS_EN
        ,
        .stall_cycles (stall_cycles),
        .grant_count  (grant_count)
`endif
    );

    always #5 clk = ~clk;

    wr_t          exp_q[$];
    logic [W-1:0] src0[$];
    logic [W-1:0] src1[$];
    int           wcyc[$];
    int           egap[$];
    int           cyc = 0;
    int           n_chk = 0;
    int           n_pass = 0;
    logic [N-1:0] hs = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic refresh();
        bus.req_valid[0]  = (src0.size() > 0);
        bus.req_valid[1]  = (src1.size() > 0);
        bus.req_data[3:0] = (src0.size() > 0) ? src0[0] : 4'h0;
        bus.req_data[7:4] = (src1.size() > 0) ? src1[0] : 4'h0;
    endtask

    task automatic expw(input logic [W-1:0] d, input logic t);
        wr_t e;
        e.d = d;
        e.t = t;
        exp_q.push_back(e);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: record handshakes for the sources and score every FIFO write.
    always @(negedge clk) begin
        wr_t e;
        hs = bus.req_valid & bus.req_ready;
        if (bus.fifo_wr_en === 1'b1) begin
            wcyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_write: got data 0x%0h tag %0d expected no write",
                         bus.fifo_wdata, bus.fifo_wtag);
            end else begin
                e = exp_q.pop_front();
                check("wr_data", 32'(bus.fifo_wdata), 32'(e.d));
                check("wr_tag", 32'(bus.fifo_wtag), 32'(e.t));
            end
        end
    end

    // Requester model: advance a source only after a completed handshake.
    always begin
        @(posedge clk);
        #1;
        if (hs[0] && src0.size() > 0) void'(src0.pop_front());
        if (hs[1] && src1.size() > 0) void'(src1.pop_front());
        refresh();
    end

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        for (k = 0; k < 200; k++) begin
            @(posedge clk);
            if (exp_q.size() == 0 && src0.size() == 0 && src1.size() == 0) break;
        end
        check({name, "_drain"}, 32'(k < 200), 32'd1);
        repeat (3) @(posedge clk);
    endtask

    task automatic check_gaps(input string name);
        check({name, "_nwrites"}, 32'(wcyc.size()), 32'(egap.size() + 1));
        for (int i = 0; i < egap.size(); i++) begin
            if (i + 1 < wcyc.size()) check({name, "_gap"}, 32'(wcyc[i+1] - wcyc[i]), 32'(egap[i]));
        end
    endtask

    task automatic wait_writes(input int n, input string name);
        int k;
        for (k = 0; k < 50; k++) begin
            @(posedge clk);
            if (wcyc.size() >= n) break;
        end
        check({name, "_wait"}, 32'(k < 50), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.fifo_full = 1'b0;

        // Reset state
        #12;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_wr_en", 32'(bus.fifo_wr_en), 32'd0);
        check("rst_ready", 32'(bus.req_ready), 32'd0);
        check("rst_wdata", 32'(bus.fifo_wdata), 32'd0);
        check("rst_wtag", 32'(bus.fifo_wtag), 32'd0);
        check("rst_owner", 32'(bus.grant_owner), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;

        // S1: single requester, 5 words -> burst of 4, bubble, regrant for the 5th
        @(posedge clk);
        #2;
        wcyc.delete();
        for (int i = 1; i <= 5; i++) begin
            src0.push_back(4'(i));
            expw(4'(i), 1'b0);
        end
        refresh();
        egap = {1, 1, 1, 2};
        drain("s1");
        check_gaps("s1");
        check("s1_idle_busy", 32'(bus.busy), 32'd0);
        check("s1_idle_owner", 32'(bus.grant_owner), 32'd0);

        // S2: both requesters continuously valid, alternating bursts of 4
        do_reset();
        #2;
        wcyc.delete();
        for (int i = 0; i < 8; i++) begin
            src0.push_back(4'hA);
            src1.push_back(4'h5);
        end
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 4; i++) begin
                if (b % 2 == 0) expw(4'hA, 1'b0);
                else            expw(4'h5, 1'b1);
            end
        end
        refresh();
        egap = {1, 1, 1, 2, 1, 1, 1, 2, 1, 1, 1, 2, 1, 1, 1};
        drain("s2");
        check_gaps("s2");

        // S3: FIFO full for 3 cycles after 2 words of a burst
        do_reset();
        #2;
        wcyc.delete();
        for (int i = 1; i <= 4; i++) begin
            src0.push_back(4'(i));
            expw(4'(i), 1'b0);
        end
        refresh();
        wait_writes(2, "s3");
        #2 bus.fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("s3_full_wr_en", 32'(bus.fifo_wr_en), 32'd0);
            check("s3_full_ready", 32'(bus.req_ready), 32'd0);
            check("s3_full_busy", 32'(bus.busy), 32'd1);
            @(posedge clk);
        end
        #2 bus.fifo_full = 1'b0;
        egap = {1, 4, 1};
        drain("s3");
        check_gaps("s3");
`ifdef FIFO_WR_ARB_STATS_EN
        check("s3_stall_cycles", 32'(stall_cycles), 32'd3);
        check("s3_grant_count0", 32'(grant_count[7:0]), 32'd1);
        check("s3_grant_count1", 32'(grant_count[15:8]), 32'd0);
`endif

        // S4: owner releases after 1 word; other pending requester is granted
        do_reset();
        #2;
        wcyc.delete();
        src0.push_back(4'h3);
        src1.push_back(4'hC);
        src1.push_back(4'hD);
        expw(4'h3, 1'b0);
        expw(4'hC, 1'b1);
        expw(4'hD, 1'b1);
        refresh();
        egap = {3, 1};
        drain("s4");
        check_gaps("s4");

        // S5: reset pulse mid-burst abandons the burst; first grant after is requester 0
        do_reset();
        #2;
        wcyc.delete();
        for (int i = 1; i <= 8; i++) src0.push_back(4'(i));
        expw(4'h1, 1'b0);
        expw(4'h2, 1'b0);
        refresh();
        wait_writes(2, "s5");
        #2 rst = 1'b1;
        #1;
        check("s5_rst_busy", 32'(bus.busy), 32'd0);
        check("s5_rst_wr_en", 32'(bus.fifo_wr_en), 32'd0);
        check("s5_rst_ready", 32'(bus.req_ready), 32'd0);
        check("s5_rst_wdata", 32'(bus.fifo_wdata), 32'd0);
        check("s5_rst_wtag", 32'(bus.fifo_wtag), 32'd0);
        check("s5_rst_owner", 32'(bus.grant_owner), 32'd0);
        @(posedge clk);
        #2;
        src1.push_back(4'hE);
        src1.push_back(4'hF);
        for (int i = 3; i <= 6; i++) expw(4'(i), 1'b0);
        expw(4'hE, 1'b1);
        expw(4'hF, 1'b1);
        expw(4'h7, 1'b0);
        expw(4'h8, 1'b0);
        refresh();
        rst = 1'b0;
        drain("s5");
        check("s5_writes", 32'(wcyc.size()), 32'd10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
